// File: rtl/weight_pkg.sv
// Shared types and helpers for the weight ping-pong buffer controller.
package weight_pkg;

  typedef enum logic [1:0] {
    HALF_FREE    = 2'd0,
    HALF_LOADING = 2'd1,
    HALF_FULL    = 2'd2,
    HALF_READING = 2'd3
  } half_state_e;

  localparam int unsigned NUM_HALVES = 32'd2;

  // Base address of a half: the select bit sits in the MSB of the buffer address.
  function automatic logic [31:0] half_base(input logic half_sel, input int unsigned addr_len);
    return {31'd0, half_sel} << (addr_len - 32'd1);
  endfunction

endpackage

// File: rtl/weight_pingpong_ctrl_if.sv
// Loader/reader handshake bundle of the weight ping-pong controller.
interface weight_pingpong_ctrl_if #(
  parameter int unsigned ADDR_LEN = 9
);
  logic                ld_req;
  logic                ld_gnt;
  logic [ADDR_LEN-1:0] ld_base;
  logic                ld_done;
  logic                rd_req;
  logic                rd_gnt;
  logic [ADDR_LEN-1:0] rd_base;
  logic                rd_done;
  logic [1:0]          full_cnt;
  logic                idle;

  modport master (
    output ld_req, ld_done, rd_req, rd_done,
    input  ld_gnt, ld_base, rd_gnt, rd_base, full_cnt, idle
  );

  modport slave (
    input  ld_req, ld_done, rd_req, rd_done,
    output ld_gnt, ld_base, rd_gnt, rd_base, full_cnt, idle
  );
endinterface

// File: rtl/weight_pingpong_ctrl_slot.sv
// wpp_slot: state register of one buffer half (FREE -> LOADING -> FULL -> READING -> FREE).
module wpp_slot
  import weight_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_grant_i,
  input  logic        ld_fin_i,
  input  logic        rd_grant_i,
  input  logic        rd_fin_i,
  output half_state_e state_o,
  output half_state_e state_d_o
);

  half_state_e state_q;
  half_state_e state_d;

  // Next-state: each event is only meaningful in the one state that can receive it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HALF_FREE:    if (ld_grant_i) state_d = HALF_LOADING; else state_d = state_q;
      HALF_LOADING: if (ld_fin_i)   state_d = HALF_FULL;    else state_d = state_q;
      HALF_FULL:    if (rd_grant_i) state_d = HALF_READING; else state_d = state_q;
      HALF_READING: if (rd_fin_i)   state_d = HALF_FREE;    else state_d = state_q;
      default:                      state_d = HALF_FREE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HALF_FREE;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o   = state_q;
  assign state_d_o = state_d;

endmodule

// File: rtl/weight_pingpong_ctrl.sv
// Ping-pong arbitration of two weight-buffer halves between a loader and a PE-array reader.
// Optional sticky err output for ignored done pulses when WPP_ERR_EN is defined.
module weight_pingpong_ctrl
  import weight_pkg::*;
#(
  parameter int unsigned ADDR_LEN = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  weight_pingpong_ctrl_if.slave  bus
`ifdef WPP_ERR_EN
  ,
  output logic                   err
`endif
);

  half_state_e         slot_q [NUM_HALVES];
  half_state_e         slot_d [NUM_HALVES];
  logic [1:0]          ld_grant_v, ld_fin_v, rd_grant_v, rd_fin_v;
  logic                ld_ptr_q, ld_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                ld_out_q, ld_out_d, rd_out_q, rd_out_d;
  logic                ld_gnt_q, ld_gnt_d, rd_gnt_q, rd_gnt_d;
  logic                ld_fin_s, rd_fin_s;
  logic [ADDR_LEN-1:0] ld_base_q, ld_base_d, rd_base_q, rd_base_d;
  logic [1:0]          full_cnt_q, full_cnt_d;
  logic                idle_q, idle_d;

  // Grant decisions use registered state only; the owned half is always the one behind the pointer.
  always_comb begin
    ld_gnt_d   = bus.ld_req && !ld_out_q && (slot_q[ld_ptr_q] == HALF_FREE);
    rd_gnt_d   = bus.rd_req && !rd_out_q && (slot_q[rd_ptr_q] == HALF_FULL);
    ld_fin_s   = bus.ld_done && ld_out_q;
    rd_fin_s   = bus.rd_done && rd_out_q;
    ld_ptr_d   = ld_gnt_d ? ~ld_ptr_q : ld_ptr_q;
    rd_ptr_d   = rd_gnt_d ? ~rd_ptr_q : rd_ptr_q;
    ld_out_d   = ld_gnt_d || (ld_out_q && !ld_fin_s);
    rd_out_d   = rd_gnt_d || (rd_out_q && !rd_fin_s);
    ld_base_d  = ld_gnt_d ? ADDR_LEN'(half_base(ld_ptr_q, ADDR_LEN)) : ld_base_q;
    rd_base_d  = rd_gnt_d ? ADDR_LEN'(half_base(rd_ptr_q, ADDR_LEN)) : rd_base_q;
    ld_grant_v = 2'b00;
    ld_fin_v   = 2'b00;
    rd_grant_v = 2'b00;
    rd_fin_v   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      ld_grant_v[i] = ld_gnt_d && (ld_ptr_q == 1'(i));
      rd_grant_v[i] = rd_gnt_d && (rd_ptr_q == 1'(i));
      ld_fin_v[i]   = ld_fin_s && (ld_ptr_q != 1'(i));
      rd_fin_v[i]   = rd_fin_s && (rd_ptr_q != 1'(i));
    end
    full_cnt_d = {1'b0, slot_d[0] == HALF_FULL} + {1'b0, slot_d[1] == HALF_FULL};
    idle_d     = (slot_d[0] == HALF_FREE) && (slot_d[1] == HALF_FREE) && !ld_out_d && !rd_out_d;
  end

  for (genvar g = 0; g < 2; g++) begin : g_slot
    wpp_slot u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .ld_grant_i (ld_grant_v[g]),
      .ld_fin_i   (ld_fin_v[g]),
      .rd_grant_i (rd_grant_v[g]),
      .rd_fin_i   (rd_fin_v[g]),
      .state_o    (slot_q[g]),
      .state_d_o  (slot_d[g])
    );
  end

  // Pointers, ownership flags and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      ld_out_q   <= 1'b0;
      rd_out_q   <= 1'b0;
      ld_gnt_q   <= 1'b0;
      rd_gnt_q   <= 1'b0;
      ld_base_q  <= '0;
      rd_base_q  <= '0;
      full_cnt_q <= 2'd0;
      idle_q     <= 1'b1;
    end else begin
      ld_ptr_q   <= ld_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ld_out_q   <= ld_out_d;
      rd_out_q   <= rd_out_d;
      ld_gnt_q   <= ld_gnt_d;
      rd_gnt_q   <= rd_gnt_d;
      ld_base_q  <= ld_base_d;
      rd_base_q  <= rd_base_d;
      full_cnt_q <= full_cnt_d;
      idle_q     <= idle_d;
    end
  end

  assign bus.ld_gnt   = ld_gnt_q;
  assign bus.rd_gnt   = rd_gnt_q;
  assign bus.ld_base  = ld_base_q;
  assign bus.rd_base  = rd_base_q;
  assign bus.full_cnt = full_cnt_q;
  assign bus.idle     = idle_q;

`ifdef WPP_ERR_EN
  logic err_q, err_d;

  // A done pulse on a side with nothing outstanding latches err until reset.
  always_comb begin
    err_d = err_q || (bus.ld_done && !ld_out_q) || (bus.rd_done && !rd_out_q);
  end

  // Sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_weight_pingpong_ctrl.sv
// Self-checking bench for weight_pingpong_ctrl: directed scenarios plus random traffic against a half-ownership model.
module tb_weight_pingpong_ctrl;

  localparam int M_FREE = 0, M_LOADING = 1, M_FULL = 2, M_READING = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   cmp_en;
`ifdef WPP_ERR_EN
  logic err;
`endif

  weight_pingpong_ctrl_if #(.ADDR_LEN(9)) wif ();

  weight_pingpong_ctrl #(.ADDR_LEN(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wif)
`ifdef WPP_ERR_EN
    ,
    .err   (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of half ownership: who holds which half, and what the outputs must show.
  int         st [2];
  bit         lp, rp, lown, rown, lhalf, rhalf, gl, gr;
  bit         m_ld_gnt, m_rd_gnt, m_idle, m_err;
  logic [8:0] m_ld_base, m_rd_base;
  int         m_full;

  task automatic model_reset();
    st[0] = M_FREE; st[1] = M_FREE;
    lp = 1'b0; rp = 1'b0; lown = 1'b0; rown = 1'b0; lhalf = 1'b0; rhalf = 1'b0;
    m_ld_gnt = 1'b0; m_rd_gnt = 1'b0; m_ld_base = 9'h000; m_rd_base = 9'h000;
    m_full = 0; m_idle = 1'b1; m_err = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        gl = wif.ld_req && !lown && (st[lp] == M_FREE);
        gr = wif.rd_req && !rown && (st[rp] == M_FULL);
        if (wif.ld_done) begin
          if (lown) begin st[lhalf] = M_FULL; lown = 1'b0; end
          else m_err = 1'b1;
        end
        if (wif.rd_done) begin
          if (rown) begin st[rhalf] = M_FREE; rown = 1'b0; end
          else m_err = 1'b1;
        end
        if (gl) begin
          st[lp] = M_LOADING; lhalf = lp; m_ld_base = lp ? 9'h100 : 9'h000; lp = !lp; lown = 1'b1;
        end
        if (gr) begin
          st[rp] = M_READING; rhalf = rp; m_rd_base = rp ? 9'h100 : 9'h000; rp = !rp; rown = 1'b1;
        end
        m_ld_gnt = gl;
        m_rd_gnt = gr;
        m_full   = ((st[0] == M_FULL) ? 1 : 0) + ((st[1] == M_FULL) ? 1 : 0);
        m_idle   = (st[0] == M_FREE) && (st[1] == M_FREE) && !lown && !rown;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of the DUT against the model, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("m_ld_gnt",   32'(wif.ld_gnt),   32'(m_ld_gnt));
        chk("m_rd_gnt",   32'(wif.rd_gnt),   32'(m_rd_gnt));
        chk("m_ld_base",  32'(wif.ld_base),  32'(m_ld_base));
        chk("m_rd_base",  32'(wif.rd_base),  32'(m_rd_base));
        chk("m_full_cnt", 32'(wif.full_cnt), 32'(m_full));
        chk("m_idle",     32'(wif.idle),     32'(m_idle));
`ifdef WPP_ERR_EN
        chk("m_err",      32'(err),          32'(m_err));
`endif
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    wif.ld_req = 1'b0; wif.ld_done = 1'b0; wif.rd_req = 1'b0; wif.rd_done = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ld_gnt"},   32'(wif.ld_gnt),   32'd0);
    chk({tag, "_rd_gnt"},   32'(wif.rd_gnt),   32'd0);
    chk({tag, "_ld_base"},  32'(wif.ld_base),  32'h000);
    chk({tag, "_rd_base"},  32'(wif.rd_base),  32'h000);
    chk({tag, "_full_cnt"}, 32'(wif.full_cnt), 32'd0);
    chk({tag, "_idle"},     32'(wif.idle),     32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cmp_en = 1'b0;
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Reader asks while nothing is loaded, then first load and read.
    wif.rd_req = 1'b1;
    repeat (3) begin step(); chk("rd_empty_gnt", 32'(wif.rd_gnt), 32'd0); end
    wif.rd_req = 1'b0;
    wif.ld_req = 1'b1; step();
    chk("ld1_gnt", 32'(wif.ld_gnt), 32'd1);
    chk("ld1_base", 32'(wif.ld_base), 32'h000);
    chk("ld1_idle", 32'(wif.idle), 32'd0);
    wif.ld_req = 1'b0; step();
    chk("ld1_pulse", 32'(wif.ld_gnt), 32'd0);
    wif.ld_done = 1'b1; wif.rd_req = 1'b1; step();
    chk("full_vis_cnt", 32'(wif.full_cnt), 32'd1);
    chk("full_vis_rdgnt", 32'(wif.rd_gnt), 32'd0);
    wif.ld_done = 1'b0; step();
    chk("rd1_gnt", 32'(wif.rd_gnt), 32'd1);
    chk("rd1_base", 32'(wif.rd_base), 32'h000);
    chk("rd1_full", 32'(wif.full_cnt), 32'd0);
    wif.rd_req = 1'b0; wif.ld_req = 1'b1; step();
    chk("ld2_gnt", 32'(wif.ld_gnt), 32'd1);
    chk("ld2_base", 32'(wif.ld_base), 32'h100);
    wif.ld_req = 1'b0; wif.ld_done = 1'b1; wif.rd_done = 1'b1; step();
    chk("same_edge_full", 32'(wif.full_cnt), 32'd1);
    chk("same_edge_idle", 32'(wif.idle), 32'd0);
    wif.ld_done = 1'b0; wif.rd_done = 1'b0; wif.rd_req = 1'b1; step();
    chk("rd2_gnt", 32'(wif.rd_gnt), 32'd1);
    chk("rd2_base", 32'(wif.rd_base), 32'h100);
    wif.rd_req = 1'b0; wif.rd_done = 1'b1; step();
    wif.rd_done = 1'b0;
    chk("drain_full", 32'(wif.full_cnt), 32'd0);
    chk("drain_idle", 32'(wif.idle), 32'd1);
`ifdef WPP_ERR_EN
    chk("err_clean", 32'(err), 32'd0);
    wif.rd_done = 1'b1; step();
    wif.rd_done = 1'b0;
    chk("err_set", 32'(err), 32'd1);
    chk("err_full", 32'(wif.full_cnt), 32'd0);
    chk("err_idle", 32'(wif.idle), 32'd1);
    repeat (3) step();
    chk("err_sticky", 32'(err), 32'd1);
`endif

    // Both halves full with the loader held off until half 0 drains.
    do_reset();
`ifdef WPP_ERR_EN
    chk("err_cleared", 32'(err), 32'd0);
`endif
    wif.ld_req = 1'b1; step();
    chk("b_ld0_gnt", 32'(wif.ld_gnt), 32'd1);
    chk("b_ld0_base", 32'(wif.ld_base), 32'h000);
    wif.ld_done = 1'b1; step();
    chk("b_outst_gnt", 32'(wif.ld_gnt), 32'd0);
    chk("b_full1", 32'(wif.full_cnt), 32'd1);
    wif.ld_done = 1'b0; step();
    chk("b_ld1_gnt", 32'(wif.ld_gnt), 32'd1);
    chk("b_ld1_base", 32'(wif.ld_base), 32'h100);
    wif.ld_done = 1'b1; step();
    chk("b_full2", 32'(wif.full_cnt), 32'd2);
    wif.ld_done = 1'b0; step();
    chk("b_blocked1", 32'(wif.ld_gnt), 32'd0);
    wif.rd_req = 1'b1; step();
    chk("b_blocked2", 32'(wif.ld_gnt), 32'd0);
    chk("b_rd0_gnt", 32'(wif.rd_gnt), 32'd1);
    chk("b_rd0_base", 32'(wif.rd_base), 32'h000);
    wif.rd_req = 1'b0; wif.rd_done = 1'b1; step();
    chk("b_blocked3", 32'(wif.ld_gnt), 32'd0);
    chk("b_freed_full", 32'(wif.full_cnt), 32'd1);
    wif.rd_done = 1'b0; step();
    chk("b_reload_gnt", 32'(wif.ld_gnt), 32'd1);
    chk("b_reload_base", 32'(wif.ld_base), 32'h000);
    wif.ld_req = 1'b0; wif.rd_req = 1'b1; step();
    chk("b_rd1_gnt", 32'(wif.rd_gnt), 32'd1);
    chk("b_rd1_base", 32'(wif.rd_base), 32'h100);
    wif.rd_req = 1'b0; wif.ld_done = 1'b1; wif.rd_done = 1'b1; step();
    chk("b_swap_full", 32'(wif.full_cnt), 32'd1);
    wif.ld_done = 1'b0; wif.rd_done = 1'b0; wif.ld_req = 1'b1; wif.rd_req = 1'b1; step();
    chk("b_both_ldgnt", 32'(wif.ld_gnt), 32'd1);
    chk("b_both_rdgnt", 32'(wif.rd_gnt), 32'd1);
    chk("b_both_ldbase", 32'(wif.ld_base), 32'h100);
    chk("b_both_rdbase", 32'(wif.rd_base), 32'h000);
    chk("b_both_idle", 32'(wif.idle), 32'd0);
    clear_inputs();
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("async");
    step();
    rst_n = 1'b1;

    // Random traffic, including orphan done pulses and one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      wif.ld_req  = ($urandom_range(0, 1) == 1);
      wif.rd_req  = ($urandom_range(0, 1) == 1);
      wif.ld_done = ($urandom_range(0, 3) == 0);
      wif.rd_done = ($urandom_range(0, 3) == 0);
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end
    clear_inputs();
    step();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
